// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI loopback block: master FSM states and the
// sclk half-period calculation.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Number of clk cycles per sclk half-period.
   function automatic int calc_half(input int clk_hz, input int spi_hz);
      return clk_hz / (2 * spi_hz);
   endfunction

endpackage

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampling sclk/cs_n on clk.
// SPI_SLAVE_ECHO_EN: transmit the word received in the previous transfer instead of TX_WORD.
module spi_slave
   import spi_pkg::*;
#(
   parameter int                    DATA_WIDTH = 16,
   parameter logic [DATA_WIDTH-1:0] TX_WORD    = '0
)(
   input  logic clk,
   input  logic rst_n,
   input  logic i_sclk,
   input  logic i_cs_n,
   input  logic i_mosi,
   output logic o_miso
);

   logic                  r_sclk_q;
   logic                  r_cs_n_q;
   logic [DATA_WIDTH-1:0] r_shreg;
   logic                  r_rx_bit;
   logic                  r_miso;
   logic                  w_sclk_rise;
   logic                  w_sclk_fall;
   logic                  w_cs_fall;
   logic [DATA_WIDTH-1:0] w_tx_word;

   assign w_sclk_rise = i_sclk & ~r_sclk_q;
   assign w_sclk_fall = ~i_sclk & r_sclk_q;
   assign w_cs_fall   = ~i_cs_n & r_cs_n_q;
   assign o_miso      = r_miso;

`ifdef SPI_SLAVE_ECHO_EN
   logic [DATA_WIDTH-1:0] r_rx_word;
   logic                  r_have_rx;
   logic                  w_cs_rise;

   assign w_cs_rise = i_cs_n & ~r_cs_n_q;
   assign w_tx_word = r_have_rx ? r_rx_word : TX_WORD;

   // The last falling edge is seen before cs_n rises, so r_shreg is complete here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_word <= '0;
         r_have_rx <= 1'b0;
      end else if (w_cs_rise) begin
         r_rx_word <= r_shreg;
         r_have_rx <= 1'b1;
      end
   end
`else
   assign w_tx_word = TX_WORD;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_q <= 1'b0;
         r_cs_n_q <= 1'b1;
         r_shreg  <= '0;
         r_rx_bit <= 1'b0;
         r_miso   <= 1'b0;
      end else begin
         r_sclk_q <= i_sclk;
         r_cs_n_q <= i_cs_n;
         if (w_cs_fall) begin
            r_shreg <= w_tx_word;
            r_miso  <= w_tx_word[DATA_WIDTH-1];
         end else if (!i_cs_n) begin
            if (w_sclk_rise) begin
               r_rx_bit <= i_mosi;
            end else if (w_sclk_fall) begin
               r_shreg <= {r_shreg[DATA_WIDTH-2:0], r_rx_bit};
               r_miso  <= r_shreg[DATA_WIDTH-2];
            end
         end
      end
   end

endmodule

// File: rtl/spi.sv
// SPI loopback: mode-0 master exchanging one DATA_WIDTH word with an internal spi_slave.
// Optional SPI_SLAVE_ECHO_EN makes the slave echo the previously received word.
module spi
   import spi_pkg::*;
#(
   parameter int          CLK_FREQUENCY  = 100_000_000,
   parameter int          SPI_FREQUENCY  = 5_000_000,
   parameter int          DATA_WIDTH     = 16,
   parameter logic [15:0] MASTER_TX_WORD = 16'h1234,
   parameter logic [15:0] SLAVE_TX_WORD  = 16'hA5C3
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [DATA_WIDTH-1:0] data_out_master
);

   localparam int HALF = calc_half(CLK_FREQUENCY, SPI_FREQUENCY);
   localparam int DW   = $clog2(HALF);
   localparam int BW   = $clog2(DATA_WIDTH + 1);
   localparam logic [DW-1:0]         DIV_LAST = DW'(HALF - 1);
   localparam logic [BW-1:0]         BIT_LAST = BW'(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] M_WORD   = DATA_WIDTH'(MASTER_TX_WORD);
   localparam logic [DATA_WIDTH-1:0] S_WORD   = DATA_WIDTH'(SLAVE_TX_WORD);

   state_t                r_state;
   state_t                w_next;
   logic [DW-1:0]         r_div;
   logic [BW-1:0]         r_bit_cnt;
   logic                  r_sclk;
   logic                  r_cs_n;
   logic                  r_mosi;
   logic                  r_rx_bit;
   logic [DATA_WIDTH-1:0] r_shreg;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  w_tick;
   logic                  w_load;
   logic                  w_miso;

   assign w_tick          = (r_div == DIV_LAST);
   assign data_out_master = r_data_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next = SETUP;
               w_load = 1'b1;
            end
         end
         SETUP: if (w_tick) w_next = XFER;
         // Leave on the falling edge that follows the last rising (sampling) edge.
         XFER:  if (w_tick && r_sclk && (r_bit_cnt == BIT_LAST)) w_next = DONE;
         DONE:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div      <= '0;
         r_bit_cnt  <= '0;
         r_sclk     <= 1'b0;
         r_cs_n     <= 1'b1;
         r_mosi     <= 1'b0;
         r_rx_bit   <= 1'b0;
         r_shreg    <= '0;
         r_data_out <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_div     <= '0;
               r_bit_cnt <= '0;
               r_sclk    <= 1'b0;
               r_cs_n    <= 1'b1;
               if (w_load) begin
                  r_cs_n  <= 1'b0;
                  r_shreg <= M_WORD;
                  r_mosi  <= M_WORD[DATA_WIDTH-1];
               end
            end
            SETUP: r_div <= w_tick ? '0 : r_div + DW'(1);
            XFER: begin
               r_div <= w_tick ? '0 : r_div + DW'(1);
               if (w_tick) begin
                  r_sclk <= ~r_sclk;
                  if (!r_sclk) begin
                     r_rx_bit  <= w_miso;
                     r_bit_cnt <= r_bit_cnt + BW'(1);
                  end else begin
                     r_shreg <= {r_shreg[DATA_WIDTH-2:0], r_rx_bit};
                     r_mosi  <= r_shreg[DATA_WIDTH-2];
                  end
               end
            end
            DONE: begin
               r_cs_n     <= 1'b1;
               r_data_out <= r_shreg;
            end
            default: ;
         endcase
      end
   end

   spi_slave #(
      .DATA_WIDTH (DATA_WIDTH),
      .TX_WORD    (S_WORD)
   ) u_slave (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_sclk (r_sclk),
      .i_cs_n (r_cs_n),
      .i_mosi (r_mosi),
      .o_miso (w_miso)
   );

endmodule

// File: tb/tb_spi.sv
// Bench for the spi loopback block, default parameters (16-bit, HALF=10).
// Build with SPI_SLAVE_ECHO_EN to exercise the echo configuration.
module tb_spi;
   import spi_pkg::*;

   localparam int W      = 16;
   localparam int HALF   = 100_000_000 / (2 * 5_000_000);
   localparam int LAT    = HALF * (1 + 2 * W) + 1;
   localparam logic [15:0] M_TX = 16'h1234;
   localparam logic [15:0] S_TX = 16'hA5C3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] data_out;

   int n_tests = 0;
   int n_fail  = 0;
   int n_done  = 0;

   always #5 clk = ~clk;

   spi dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .data_out_master (data_out)
   );

   // Reference: word the master should receive for the idx-th transfer since reset.
   function automatic logic [15:0] model_word(input int idx);
`ifdef SPI_SLAVE_ECHO_EN
      return (idx == 0) ? S_TX : M_TX;
`else
      return S_TX;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic single_transfer(input string tag);
      int          cyc;
      logic [15:0] exp;
      exp = model_word(n_done);
      repeat ($urandom_range(1, 8)) @(negedge clk);
      start = 1'b1;
      step();
      start = 1'b0;
      check({tag, "_csn_low"}, 32'(dut.r_cs_n), 32'd0);
      cyc = 0;
      while (dut.r_cs_n == 1'b0 && cyc < 2 * LAT) begin
         step();
         cyc++;
      end
      check({tag, "_latency"}, cyc, LAT);
      check({tag, "_data"}, 32'(data_out), 32'(exp));
      check({tag, "_slave_rx"}, 32'(dut.u_slave.r_shreg), 32'(M_TX));
      n_done++;
   endtask

   initial begin
      int   rises, first_rise, last_rise, min_int, max_int;
      int   cyc, low_len, high_len, completed, cs_low, sclk_high;
      logic prev_sclk, prev_cs, seen_low, cs;

      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) step();
      check("rst_state", 32'(dut.r_state), 32'(IDLE));
      check("rst_csn", 32'(dut.r_cs_n), 32'd1);
      check("rst_sclk", 32'(dut.r_sclk), 32'd0);
      check("rst_mosi_miso", {30'd0, dut.r_mosi, dut.w_miso}, 32'd0);
      check("rst_data", 32'(data_out), 32'd0);
      repeat (2) step();
      @(negedge clk) rst_n = 1'b1;

      // First transfer: start raised at cycle 10, with ignored random start pulses mid-transfer.
      repeat (4) @(negedge clk);
      start = 1'b1;
      step();
      start = 1'b0;
      check("t1_csn_low", 32'(dut.r_cs_n), 32'd0);
      rises = 0; first_rise = -1; last_rise = -1;
      min_int = 1 << 20; max_int = 0; prev_sclk = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         step();
         if (!prev_sclk && dut.r_sclk && !dut.r_cs_n) begin
            rises++;
            if (last_rise < 0) first_rise = k;
            else begin
               if (k - last_rise < min_int) min_int = k - last_rise;
               if (k - last_rise > max_int) max_int = k - last_rise;
            end
            last_rise = k;
         end
         prev_sclk = dut.r_sclk;
         if (k == LAT - 1) check("t1_no_partial", 32'(data_out), 32'd0);
         start = (k < LAT - 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      check("t1_data", 32'(data_out), 32'(model_word(0)));
      check("t1_slave_rx", 32'(dut.u_slave.r_shreg), 32'(M_TX));
      check("t1_rises", rises, W);
      check("t1_first_rise", first_rise, 2 * HALF);
      check("t1_min_period", min_int, 2 * HALF);
      check("t1_max_period", max_int, 2 * HALF);
      check("t1_csn_high", 32'(dut.r_cs_n), 32'd1);
      n_done = 1;

      // start held high: three back-to-back transfers.
      @(negedge clk) start = 1'b1;
      prev_cs = 1'b1; seen_low = 1'b0;
      low_len = 0; high_len = 0; completed = 0; cyc = 0;
      while (completed < 3 && cyc < 5 * LAT) begin
         step();
         cyc++;
         cs = dut.r_cs_n;
         if (!cs) begin
            if (prev_cs && seen_low) check("b2b_gap", high_len, 1);
            low_len++;
            seen_low = 1'b1;
         end else begin
            if (!prev_cs) begin
               check("b2b_low_len", low_len, LAT);
               check("b2b_data", 32'(data_out), 32'(model_word(n_done)));
               n_done++;
               completed++;
               low_len = 0;
               high_len = 0;
               if (completed == 3) start = 1'b0;
            end
            high_len++;
         end
         prev_cs = cs;
      end
      start = 1'b0;
      check("b2b_completed", completed, 3);

      // Abort with reset in the middle of bit 7.
      repeat (3) step();
      @(negedge clk) start = 1'b1;
      step();
      start = 1'b0;
      rises = 0; prev_sclk = 1'b0; cyc = 0;
      while (rises < 7 && cyc < LAT) begin
         step();
         cyc++;
         if (!prev_sclk && dut.r_sclk) rises++;
         prev_sclk = dut.r_sclk;
      end
      check("abort_reached_bit7", rises, 7);
      repeat ($urandom_range(0, HALF - 1)) step();
      rst_n = 1'b0;
      #1;
      check("abort_csn", 32'(dut.r_cs_n), 32'd1);
      check("abort_sclk", 32'(dut.r_sclk), 32'd0);
      check("abort_data", 32'(data_out), 32'd0);
      check("abort_state", 32'(dut.r_state), 32'(IDLE));
      n_done = 0;
      @(negedge clk) rst_n = 1'b1;
      single_transfer("post_abort");
      single_transfer("post_abort2");

      // Idle after reset: nothing may toggle.
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      n_done = 0;
      cs_low = 0; sclk_high = 0;
      repeat (1000) begin
         step();
         if (!dut.r_cs_n) cs_low++;
         if (dut.r_sclk) sclk_high++;
      end
      check("idle_csn_low_cycles", cs_low, 0);
      check("idle_sclk_high_cycles", sclk_high, 0);
      check("idle_data", 32'(data_out), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
